vote_tally_engine: RTL and testbench

Parametrised successor to the fixed four-candidate vote counter. It counts votes for NUM_CAND candidates with CNT_W-bit saturating counters. Each vote must be authorised by a one-shot ballot arm from the polling officer, and each button press is edge-detected. Ballots with more than one simultaneous press are rejected. After each accepted vote a cooldown lockout applies. In result mode it reports the leader and tie status. It sits between the button/debounce front end and the display/result mux.

---
 rtl/vote_tally_engine_if.sv | 34 +++
 rtl/vote_tally_engine.sv | 161 ++++++++++++++++
 tb/tb_vote_tally_engine.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vote_tally_engine_if.sv
// Bundles the voting front-end inputs and tally/result outputs of vote_tally_engine.
// master drives the buttons, arm and mode; slave is the tally engine itself.
interface vote_tally_engine_if #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8
);
    localparam int IDX_W = (NUM_CAND > 2) ? $clog2(NUM_CAND) : 1;
    localparam int TOT_W = CNT_W + IDX_W;

    logic                      mode;
    logic                      ballot_arm;
    logic [NUM_CAND-1:0]       cand_vote;
    logic                      ready;
    logic                      vote_ack;
    logic                      vote_rej;
    logic [IDX_W-1:0]          ack_idx;
    logic [NUM_CAND*CNT_W-1:0] cand_count;
    logic [TOT_W-1:0]          total_count;
    logic [NUM_CAND-1:0]       sat;
    logic [IDX_W-1:0]          leader_idx;
    logic                      leader_tie;

    modport master (
        output mode, ballot_arm, cand_vote,
        input  ready, vote_ack, vote_rej, ack_idx, cand_count, total_count, sat,
               leader_idx, leader_tie
    );

    modport slave (
        input  mode, ballot_arm, cand_vote,
        output ready, vote_ack, vote_rej, ack_idx, cand_count, total_count, sat,
               leader_idx, leader_tie
    );
endinterface

// File: rtl/vote_tally_engine.sv
// Officer-armed, edge-detected vote counter with saturating tallies, cooldown lockout and leader report.
// Press-to-count latency is one cycle; all outputs are registered.
module vote_tally_engine #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int LOCK_CYC = 4
) (
    input logic                clock,
    input logic                reset,
    vote_tally_engine_if.slave vt_if
);
    localparam int IDX_W = (NUM_CAND > 2) ? $clog2(NUM_CAND) : 1;
    localparam int TOT_W = CNT_W + IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [TOT_W-1:0] TOT_ONE   = TOT_W'(1);
    localparam logic [7:0]       LOCK_LAST = (LOCK_CYC > 0) ? 8'(LOCK_CYC - 1) : 8'd0;

    typedef enum logic [1:0] {IDLE, ARMED, COOLDOWN} state_t;

    state_t              state_q, state_d;
    logic [7:0]          lock_q, lock_d;
    logic [NUM_CAND-1:0] prev_q;
    logic [CNT_W-1:0]    cnt_q [NUM_CAND];
    logic [CNT_W-1:0]    cnt_d [NUM_CAND];
    logic [NUM_CAND-1:0] sat_q, sat_d;
    logic [TOT_W-1:0]    total_q, total_d;
    logic [IDX_W-1:0]    ack_idx_q, ack_idx_d;
    logic                vote_ack_q, vote_ack_d;
    logic                vote_rej_q, vote_rej_d;
    logic                ready_q, ready_d;
    logic [IDX_W-1:0]    leader_idx_q, leader_idx_d;
    logic                leader_tie_q, leader_tie_d;

    logic [NUM_CAND-1:0] press_edge;
    logic                press_one_hot;
    logic [IDX_W-1:0]    press_idx;
    logic [CNT_W-1:0]    best_val;
    logic [IDX_W-1:0]    best_idx;
    logic                best_seen;
    logic                best_tie;
    logic [NUM_CAND*CNT_W-1:0] cnt_flat;

    // Only a fresh rising edge counts, so a button held through arming is ignored.
    always_comb begin
        press_edge    = vt_if.cand_vote & ~prev_q;
        press_one_hot = $onehot(press_edge);
        press_idx     = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (press_edge[i]) press_idx = IDX_W'(i);
        end
    end

    // Strict '>' keeps the lowest index on equal maxima.
    always_comb begin
        best_val = cnt_q[0];
        best_idx = '0;
        for (int i = 1; i < NUM_CAND; i++) begin
            if (cnt_q[i] > best_val) begin
                best_val = cnt_q[i];
                best_idx = IDX_W'(i);
            end
        end
        best_seen = 1'b0;
        best_tie  = 1'b0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (cnt_q[i] == best_val) begin
                if (best_seen) best_tie = 1'b1;
                best_seen = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_d     = lock_q;
        cnt_d      = cnt_q;
        sat_d      = sat_q;
        total_d    = total_q;
        ack_idx_d  = ack_idx_q;
        vote_ack_d = 1'b0;
        vote_rej_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (vt_if.ballot_arm && !vt_if.mode) state_d = ARMED;
            end
            ARMED: begin
                if (vt_if.mode) begin
                    state_d = IDLE;
                end else if (press_one_hot) begin
                    vote_ack_d = 1'b1;
                    ack_idx_d  = press_idx;
                    // A full counter swallows the vote so the total stays equal to the sum.
                    if (cnt_q[press_idx] == CNT_MAX) begin
                        sat_d[press_idx] = 1'b1;
                    end else begin
                        cnt_d[press_idx] = cnt_q[press_idx] + CNT_ONE;
                        total_d          = total_q + TOT_ONE;
                    end
                    lock_d  = '0;
                    state_d = (LOCK_CYC == 0) ? IDLE : COOLDOWN;
                end else if (press_edge != '0) begin
                    vote_rej_d = 1'b1;
                end
            end
            COOLDOWN: begin
                if (lock_q == LOCK_LAST) state_d = IDLE;
                else                     lock_d  = lock_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
        ready_d      = (state_d == ARMED);
        leader_idx_d = vt_if.mode ? best_idx : '0;
        leader_tie_d = vt_if.mode & best_tie;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            lock_q       <= '0;
            prev_q       <= '0;
            cnt_q        <= '{default: '0};
            sat_q        <= '0;
            total_q      <= '0;
            ack_idx_q    <= '0;
            vote_ack_q   <= 1'b0;
            vote_rej_q   <= 1'b0;
            ready_q      <= 1'b0;
            leader_idx_q <= '0;
            leader_tie_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_q       <= lock_d;
            prev_q       <= vt_if.cand_vote;
            cnt_q        <= cnt_d;
            sat_q        <= sat_d;
            total_q      <= total_d;
            ack_idx_q    <= ack_idx_d;
            vote_ack_q   <= vote_ack_d;
            vote_rej_q   <= vote_rej_d;
            ready_q      <= ready_d;
            leader_idx_q <= leader_idx_d;
            leader_tie_q <= leader_tie_d;
        end
    end

    always_comb begin
        cnt_flat = '0;
        for (int i = 0; i < NUM_CAND; i++) cnt_flat[i*CNT_W +: CNT_W] = cnt_q[i];
    end

    assign vt_if.ready       = ready_q;
    assign vt_if.vote_ack    = vote_ack_q;
    assign vt_if.vote_rej    = vote_rej_q;
    assign vt_if.ack_idx     = ack_idx_q;
    assign vt_if.cand_count  = cnt_flat;
    assign vt_if.total_count = total_q;
    assign vt_if.sat         = sat_q;
    assign vt_if.leader_idx  = leader_idx_q;
    assign vt_if.leader_tie  = leader_tie_q;
endmodule

// File: tb/tb_vote_tally_engine.sv
// Directed scenarios plus randomized traffic against a ballot-level reference model.
module tb_vote_tally_engine;
    localparam int NUM_CAND = 4;
    localparam int CNT_W    = 4;
    localparam int LOCK_CYC = 4;
    localparam int IDX_W    = 2;
    localparam int TOT_W    = CNT_W + IDX_W;
    localparam int MAXV     = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    vote_tally_engine_if #(.NUM_CAND(NUM_CAND), .CNT_W(CNT_W)) vt_if ();

    vote_tally_engine #(.NUM_CAND(NUM_CAND), .CNT_W(CNT_W), .LOCK_CYC(LOCK_CYC)) dut (
        .clock (clock),
        .reset (reset),
        .vt_if (vt_if)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: ballot-level view of the engine.
    logic [NUM_CAND-1:0] m_prev = '0;
    bit                  m_armed = 0;
    int                  m_lock_left = 0;
    int                  m_cnt [NUM_CAND] = '{default: 0};
    logic [NUM_CAND-1:0] m_sat = '0;
    int                  m_total = 0;
    bit                  m_ack = 0, m_rej = 0, m_ready = 0, m_ltie = 0;
    int                  m_ack_idx = 0, m_lidx = 0;

    function automatic int dut_cnt(input int i);
        return int'(vt_if.cand_count[i*CNT_W +: CNT_W]);
    endfunction

    function automatic logic [NUM_CAND*CNT_W-1:0] exp_flat();
        logic [NUM_CAND*CNT_W-1:0] f;
        f = '0;
        for (int i = 0; i < NUM_CAND; i++) f[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
        return f;
    endfunction

    task automatic model_update(input logic r, input logic m, input logic a, input logic [NUM_CAND-1:0] v);
        logic [NUM_CAND-1:0] e;
        int n, idx, mx, nmax;
        e = v & ~m_prev;
        m_ack = 0;
        m_rej = 0;
        if (r) begin
            m_prev = '0; m_armed = 0; m_lock_left = 0; m_sat = '0; m_total = 0;
            m_ack_idx = 0; m_lidx = 0; m_ltie = 0; m_ready = 0;
            for (int i = 0; i < NUM_CAND; i++) m_cnt[i] = 0;
            return;
        end
        m_prev = v;
        mx = 0;
        for (int i = 0; i < NUM_CAND; i++) if (m_cnt[i] > mx) mx = m_cnt[i];
        nmax = 0;
        m_lidx = -1;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (m_cnt[i] == mx) begin
                nmax++;
                if (m_lidx < 0) m_lidx = i;
            end
        end
        if (!m) begin m_lidx = 0; m_ltie = 0; end
        else m_ltie = (nmax > 1);
        n = $countones(e);
        if (m_lock_left > 0) m_lock_left--;
        else if (!m_armed) m_armed = a && !m;
        else if (m) m_armed = 0;
        else if (n == 1) begin
            idx = 0;
            for (int i = 0; i < NUM_CAND; i++) if (e[i]) idx = i;
            m_ack = 1;
            m_ack_idx = idx;
            if (m_cnt[idx] == MAXV) m_sat[idx] = 1'b1;
            else begin m_cnt[idx]++; m_total++; end
            m_armed = 0;
            m_lock_left = LOCK_CYC;
        end else if (n > 1) m_rej = 1;
        m_ready = m_armed;
    endtask

    task automatic step(input logic r, input logic m, input logic a, input logic [NUM_CAND-1:0] v);
        reset = r;
        vt_if.mode = m;
        vt_if.ballot_arm = a;
        vt_if.cand_vote = v;
        @(posedge clock);
        model_update(r, m, a, v);
        @(negedge clock);
    endtask

    task automatic cast_vote(input int idx, output bit acked);
        logic [NUM_CAND-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        step(0, 0, 1, '0);
        step(0, 0, 0, oh);
        acked = vt_if.vote_ack;
        for (int k = 0; k < LOCK_CYC; k++) step(0, 0, 0, '0);
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        outs = {vt_if.ready, vt_if.vote_ack, vt_if.vote_rej, vt_if.ack_idx, vt_if.total_count,
                vt_if.sat, vt_if.leader_idx, vt_if.leader_tie};
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got %0h want 0", outs);
        end
        vectors++;
        if (vt_if.cand_count !== '0) begin
            miscompares++;
            $display("FAIL reset_counts got %0h want 0", vt_if.cand_count);
        end
        step(0, 1, 1, '0);
        vectors++;
        if ({vt_if.leader_idx, vt_if.leader_tie, vt_if.ready} !== {2'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL zero_leader idx=%0d tie=%0b ready=%0b want 0/1/0",
                     vt_if.leader_idx, vt_if.leader_tie, vt_if.ready);
        end
        step(0, 0, 0, '0);
        vectors++;
        if ({vt_if.leader_idx, vt_if.leader_tie} !== 3'b000) begin
            miscompares++;
            $display("FAIL leader_voting_mode idx=%0d tie=%0b want 0/0", vt_if.leader_idx, vt_if.leader_tie);
        end
    endtask

    task automatic test_basic_vote();
        step(1, 0, 0, '0);
        step(0, 0, 1, '0);
        vectors++;
        if (vt_if.ready !== 1'b1) begin
            miscompares++;
            $display("FAIL arm_ready got %0b want 1", vt_if.ready);
        end
        step(0, 0, 0, 4'b0100);
        vectors++;
        if ({vt_if.vote_ack, vt_if.ack_idx, vt_if.ready} !== {1'b1, 2'd2, 1'b0} ||
            dut_cnt(2) != 1 || vt_if.total_count !== TOT_W'(1)) begin
            miscompares++;
            $display("FAIL first_vote ack=%0b idx=%0d ready=%0b cnt2=%0d total=%0d want 1/2/0/1/1",
                     vt_if.vote_ack, vt_if.ack_idx, vt_if.ready, dut_cnt(2), vt_if.total_count);
        end
        for (int k = 0; k < LOCK_CYC; k++) begin
            step(0, 0, 1, 4'b0100);
            vectors++;
            if ({vt_if.ready, vt_if.vote_ack} !== 2'b00) begin
                miscompares++;
                $display("FAIL cooldown_arm k=%0d ready=%0b ack=%0b want 0/0", k, vt_if.ready, vt_if.vote_ack);
            end
        end
        step(0, 0, 1, 4'b0100);
        vectors++;
        if (vt_if.ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rearm_after_cooldown ready=%0b want 1", vt_if.ready);
        end
    endtask

    task automatic test_held_button();
        step(1, 0, 0, '0);
        step(0, 0, 0, 4'b0010);
        step(0, 0, 1, 4'b0010);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, (k < 2) ? 4'b0010 : 4'b0000);
            vectors++;
            if (vt_if.vote_ack !== 1'b0 || vt_if.ready !== 1'b1) begin
                miscompares++;
                $display("FAIL held_no_ack k=%0d ack=%0b ready=%0b want 0/1", k, vt_if.vote_ack, vt_if.ready);
            end
        end
        step(0, 0, 0, 4'b0010);
        vectors++;
        if (vt_if.vote_ack !== 1'b1 || dut_cnt(1) != 1) begin
            miscompares++;
            $display("FAIL repress_counts ack=%0b cnt1=%0d want 1/1", vt_if.vote_ack, dut_cnt(1));
        end
    endtask

    task automatic test_multi_press();
        step(1, 0, 0, '0);
        step(0, 0, 1, '0);
        step(0, 0, 0, 4'b1001);
        vectors++;
        if ({vt_if.vote_rej, vt_if.vote_ack, vt_if.ready} !== 3'b101 || vt_if.cand_count !== '0) begin
            miscompares++;
            $display("FAIL multi_reject rej=%0b ack=%0b ready=%0b counts=%0h want 1/0/1/0",
                     vt_if.vote_rej, vt_if.vote_ack, vt_if.ready, vt_if.cand_count);
        end
        step(0, 0, 0, 4'b0000);
        vectors++;
        if (vt_if.vote_rej !== 1'b0) begin
            miscompares++;
            $display("FAIL reject_one_cycle rej=%0b want 0", vt_if.vote_rej);
        end
        step(0, 0, 0, 4'b1000);
        vectors++;
        if (vt_if.vote_ack !== 1'b1 || vt_if.ack_idx !== 2'd3 || dut_cnt(3) != 1) begin
            miscompares++;
            $display("FAIL single_after_reject ack=%0b idx=%0d cnt3=%0d want 1/3/1",
                     vt_if.vote_ack, vt_if.ack_idx, dut_cnt(3));
        end
    endtask

    task automatic test_cooldown_ignore();
        step(1, 0, 0, '0);
        step(0, 0, 1, '0);
        step(0, 0, 0, 4'b0100);
        for (int k = 0; k < LOCK_CYC; k++) begin
            step(0, 0, 1, (k % 2 == 0) ? 4'b0001 : 4'b0000);
            vectors++;
            if (vt_if.vote_ack !== 1'b0 || dut_cnt(0) != 0) begin
                miscompares++;
                $display("FAIL cooldown_press k=%0d ack=%0b cnt0=%0d want 0/0", k, vt_if.vote_ack, dut_cnt(0));
            end
        end
    endtask

    task automatic test_saturation();
        int acks;
        bit acked;
        acks = 0;
        step(1, 0, 0, '0);
        for (int n = 0; n < MAXV + 2; n++) begin
            cast_vote(1, acked);
            acks += int'(acked);
            if (n == MAXV - 2) begin
                vectors++;
                if (vt_if.sat !== '0 || dut_cnt(1) != MAXV - 1) begin
                    miscompares++;
                    $display("FAIL pre_saturation sat=%0b cnt1=%0d want 0/%0d", vt_if.sat, dut_cnt(1), MAXV - 1);
                end
            end
        end
        vectors++;
        if (dut_cnt(1) != MAXV || vt_if.sat !== 4'b0010 || vt_if.total_count !== TOT_W'(MAXV) || acks != MAXV + 2) begin
            miscompares++;
            $display("FAIL saturation cnt1=%0d sat=%0b total=%0d acks=%0d want %0d/0010/%0d/%0d",
                     dut_cnt(1), vt_if.sat, vt_if.total_count, acks, MAXV, MAXV, MAXV + 2);
        end
    endtask

    task automatic test_leader();
        int want [NUM_CAND] = '{3, 5, 5, 1};
        bit acked;
        step(1, 0, 0, '0);
        for (int c = 0; c < NUM_CAND; c++)
            for (int n = 0; n < want[c]; n++) cast_vote(c, acked);
        vectors++;
        if (vt_if.leader_idx !== 2'd0 || vt_if.leader_tie !== 1'b0) begin
            miscompares++;
            $display("FAIL leader_hidden idx=%0d tie=%0b want 0/0", vt_if.leader_idx, vt_if.leader_tie);
        end
        step(0, 1, 0, '0);
        vectors++;
        if (vt_if.leader_idx !== 2'd1 || vt_if.leader_tie !== 1'b1) begin
            miscompares++;
            $display("FAIL leader_tie idx=%0d tie=%0b want 1/1", vt_if.leader_idx, vt_if.leader_tie);
        end
        step(0, 1, 1, '0);
        vectors++;
        if (vt_if.ready !== 1'b0) begin
            miscompares++;
            $display("FAIL arm_in_result ready=%0b want 0", vt_if.ready);
        end
        cast_vote(2, acked);
        step(0, 1, 0, '0);
        vectors++;
        if (vt_if.leader_idx !== 2'd2 || vt_if.leader_tie !== 1'b0 || dut_cnt(2) != 6) begin
            miscompares++;
            $display("FAIL leader_unique idx=%0d tie=%0b cnt2=%0d want 2/0/6",
                     vt_if.leader_idx, vt_if.leader_tie, dut_cnt(2));
        end
    endtask

    task automatic test_random();
        logic [NUM_CAND-1:0] v;
        logic r, m, a;
        v = '0;
        step(1, 0, 0, '0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r = ($urandom_range(0, 599) == 0);
            m = ($urandom_range(0, 7) == 0);
            a = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0: v = NUM_CAND'($urandom_range(0, (1 << NUM_CAND) - 1));
                1: v = '0;
                default: v = v;
            endcase
            step(r, m, a, v);
            vectors++;
            if ({vt_if.ready, vt_if.vote_ack, vt_if.vote_rej} !== {m_ready, m_ack, m_rej}) begin
                miscompares++;
                $display("FAIL rand_flags cyc=%0d got rdy/ack/rej=%0b%0b%0b want %0b%0b%0b", cyc,
                         vt_if.ready, vt_if.vote_ack, vt_if.vote_rej, m_ready, m_ack, m_rej);
            end
            vectors++;
            if (vt_if.ack_idx !== IDX_W'(m_ack_idx)) begin
                miscompares++;
                $display("FAIL rand_ack_idx cyc=%0d got %0d want %0d", cyc, vt_if.ack_idx, m_ack_idx);
            end
            vectors++;
            if (vt_if.cand_count !== exp_flat()) begin
                miscompares++;
                $display("FAIL rand_counts cyc=%0d got %0h want %0h", cyc, vt_if.cand_count, exp_flat());
            end
            vectors++;
            if (vt_if.total_count !== TOT_W'(m_total)) begin
                miscompares++;
                $display("FAIL rand_total cyc=%0d got %0d want %0d", cyc, vt_if.total_count, m_total);
            end
            vectors++;
            if (vt_if.sat !== m_sat) begin
                miscompares++;
                $display("FAIL rand_sat cyc=%0d got %0b want %0b", cyc, vt_if.sat, m_sat);
            end
            vectors++;
            if (vt_if.leader_idx !== IDX_W'(m_lidx) || vt_if.leader_tie !== m_ltie) begin
                miscompares++;
                $display("FAIL rand_leader cyc=%0d got %0d/%0b want %0d/%0b", cyc,
                         vt_if.leader_idx, vt_if.leader_tie, m_lidx, m_ltie);
            end
        end
    endtask

    initial begin
        vt_if.mode = 1'b0;
        vt_if.ballot_arm = 1'b0;
        vt_if.cand_vote = '0;
        test_reset();
        test_basic_vote();
        test_held_button();
        test_multi_press();
        test_cooldown_ignore();
        test_saturation();
        test_leader();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
